// File: rtl/mem_ctrl.sv
// Load/store sequencer: turns byte/half/word requests into aligned 32-bit mmu cycles.
// Sub-word stores use read-modify-write; the strobe registers never drop together.
module mem_ctrl #(
  parameter int unsigned WE_CYCLES   = 1,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        N_RST,
  input  logic        REQ,
  input  logic        WE,
  input  logic [1:0]  SIZE,
  input  logic        SIGNED,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        READY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic [31:0] MEM_ADDR,
  output logic        MEM_N_WE,
  output logic        MEM_N_OE,
  output logic [31:0] MEM_OUT,
  input  logic [31:0] MEM_IN
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, HOLD, RESP} state_t;

  localparam logic [1:0] WE_LOAD   = 2'(WE_CYCLES - 1);
  localparam logic [1:0] HOLD_LOAD = 2'(HOLD_CYCLES - 1);

  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  lane;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [15:0] wdata_q;

  logic        err_req;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;
  logic [31:0] rmw_word;

  assign READY = (state == IDLE);

  assign err_req = (SIZE == 2'b11) ||
                   (SIZE == 2'b01 && ADDR[0]) ||
                   (SIZE == 2'b10 && ADDR[1:0] != 2'b00);

  always_comb begin
    rd_byte  = MEM_IN[{lane, 3'b000} +: 8];
    rd_half  = MEM_IN[{lane[1], 4'b0000} +: 16];
    rd_ext   = MEM_IN;
    rmw_word = MEM_IN;
    case (size_q)
      2'b00: begin
        rd_ext = {{24{sgn_q & rd_byte[7]}}, rd_byte};
        rmw_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        rd_ext = {{16{sgn_q & rd_half[15]}}, rd_half};
        rmw_word[{lane[1], 4'b0000} +: 16] = wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      state    <= IDLE;
      cnt      <= '0;
      lane     <= '0;
      size_q   <= '0;
      sgn_q    <= 1'b0;
      wdata_q  <= '0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      RDATA    <= '0;
      MEM_ADDR <= '0;
      MEM_OUT  <= '0;
      MEM_N_WE <= 1'b1;
      MEM_N_OE <= 1'b1;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ) begin
            lane    <= ADDR[1:0];
            size_q  <= SIZE;
            sgn_q   <= SIGNED;
            wdata_q <= WDATA[15:0];
            if (err_req) begin
              state <= RESP;
              DONE  <= 1'b1;
              ERR   <= 1'b1;
            end else begin
              MEM_ADDR <= {ADDR[31:2], 2'b00};
              if (!WE) begin
                state    <= RD;
                MEM_N_OE <= 1'b0;
              end else if (SIZE == 2'b10) begin
                state    <= WR;
                MEM_OUT  <= WDATA;
                MEM_N_WE <= 1'b0;
                cnt      <= WE_LOAD;
              end else begin
                state    <= RMW_RD;
                MEM_N_OE <= 1'b0;
              end
            end
          end
        end
        RD: begin
          RDATA    <= rd_ext;
          MEM_N_OE <= 1'b1;
          DONE     <= 1'b1;
          state    <= RESP;
        end
        RMW_RD: begin
          // OE releases on the same edge WE asserts; both are flops, so no overlap.
          MEM_OUT  <= rmw_word;
          MEM_N_OE <= 1'b1;
          MEM_N_WE <= 1'b0;
          cnt      <= WE_LOAD;
          state    <= WR;
        end
        WR: begin
          if (cnt == 2'd0) begin
            MEM_N_WE <= 1'b1;
            if (HOLD_CYCLES == 0) begin
              DONE  <= 1'b1;
              state <= RESP;
            end else begin
              cnt   <= HOLD_LOAD;
              state <= HOLD;
            end
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        HOLD: begin
          if (cnt == 2'd0) begin
            DONE  <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: default instance plus a WE_CYCLES=3/HOLD_CYCLES=2 instance.
// Driver pushes expected responses; the negedge monitor pops and checks them on DONE.
module tb_mem_ctrl;

  logic        CLK = 1'b0;
  logic        N_RST = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = '0;
  logic        sgn_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] mem_in = '0;

  logic        req   [2] = '{1'b0, 1'b0};
  logic        ready [2];
  logic        done  [2];
  logic        err   [2];
  logic [31:0] rdata [2];
  logic [31:0] maddr [2];
  logic        nwe   [2];
  logic        noe   [2];
  logic [31:0] mout  [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int overlap_n = 0;
  int align_n = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  mem_ctrl u_dut0 (
    .CLK(CLK), .N_RST(N_RST), .REQ(req[0]), .WE(we_i), .SIZE(size_i), .SIGNED(sgn_i),
    .ADDR(addr_i), .WDATA(wdata_i), .READY(ready[0]), .DONE(done[0]), .ERR(err[0]),
    .RDATA(rdata[0]), .MEM_ADDR(maddr[0]), .MEM_N_WE(nwe[0]), .MEM_N_OE(noe[0]),
    .MEM_OUT(mout[0]), .MEM_IN(mem_in)
  );

  mem_ctrl #(.WE_CYCLES(3), .HOLD_CYCLES(2)) u_dut1 (
    .CLK(CLK), .N_RST(N_RST), .REQ(req[1]), .WE(we_i), .SIZE(size_i), .SIGNED(sgn_i),
    .ADDR(addr_i), .WDATA(wdata_i), .READY(ready[1]), .DONE(done[1]), .ERR(err[1]),
    .RDATA(rdata[1]), .MEM_ADDR(maddr[1]), .MEM_N_WE(nwe[1]), .MEM_N_OE(noe[1]),
    .MEM_OUT(mout[1]), .MEM_IN(mem_in)
  );

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic [31:0] mout;
    int          oe_n;
    int          we_n;
    int          addr_n;
    int          out_n;
  } item_t;

  item_t q0[$];
  item_t q1[$];

  item_t cur     [2];
  logic  active  [2] = '{1'b0, 1'b0};
  logic  we_seen [2];
  int    acc     [2];
  int    oe_c    [2];
  int    we_c    [2];
  int    addr_c  [2];
  int    out_c   [2];
  int    done_n  [2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic item_t mk(input int lat, input logic e, input logic [31:0] rd,
                               input logic [31:0] ma, input logic [31:0] mo,
                               input int oe, input int we, input int an, input int on);
    item_t it;
    it.lat = lat; it.err = e; it.rdata = rd; it.maddr = ma; it.mout = mo;
    it.oe_n = oe; it.we_n = we; it.addr_n = an; it.out_n = on;
    return it;
  endfunction

  // Monitor: per-cycle strobe/address bookkeeping, response checks on DONE.
  always @(negedge CLK) begin
    if (!N_RST) begin
      q0.delete();
      q1.delete();
      active[0] = 1'b0;
      active[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!noe[d] && !nwe[d]) overlap_n++;
        if (maddr[d][1:0] != 2'b00) align_n++;
        if (active[d]) begin
          if (!noe[d]) oe_c[d]++;
          if (!nwe[d]) begin
            we_c[d]++;
            we_seen[d] = 1'b1;
          end
          if (!done[d]) begin
            if (maddr[d] == cur[d].maddr) addr_c[d]++;
            if (we_seen[d] && mout[d] == cur[d].mout) out_c[d]++;
          end
        end
        if (done[d]) begin
          done_n[d]++;
          if (!active[d]) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done dut%0d: got DONE=1 expected no DONE", d);
          end else begin
            chk($sformatf("latency_dut%0d", d), cyc - acc[d], cur[d].lat);
            chk($sformatf("err_dut%0d", d), {31'd0, err[d]}, {31'd0, cur[d].err});
            chk($sformatf("rdata_dut%0d", d), rdata[d], cur[d].rdata);
            chk($sformatf("oe_cycles_dut%0d", d), oe_c[d], cur[d].oe_n);
            chk($sformatf("we_cycles_dut%0d", d), we_c[d], cur[d].we_n);
            chk($sformatf("addr_stable_dut%0d", d), addr_c[d], cur[d].addr_n);
            chk($sformatf("out_stable_dut%0d", d), out_c[d], cur[d].out_n);
            active[d] = 1'b0;
          end
        end
        if (req[d] && ready[d]) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept dut%0d: got accept expected none", d);
          end else begin
            if (d == 0) cur[d] = q0.pop_front();
            else        cur[d] = q1.pop_front();
            active[d]  = 1'b1;
            we_seen[d] = 1'b0;
            acc[d]     = cyc;
            oe_c[d]    = 0;
            we_c[d]    = 0;
            addr_c[d]  = 0;
            out_c[d]   = 0;
          end
        end
      end
    end
  end

  task automatic drive(input int d, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mi,
                       input item_t it);
    int n;
    n = 0;
    while (!ready[d] && n < 50) begin
      @(posedge CLK); #2;
      n++;
    end
    mem_in = mi; we_i = w; size_i = sz; sgn_i = sg; addr_i = a; wdata_i = wd;
    if (d == 0) q0.push_back(it);
    else        q1.push_back(it);
    req[d] = 1'b1;
    @(posedge CLK); #2;
    req[d] = 1'b0;
  endtask

  task automatic run(input int d, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mi,
                     input item_t it);
    int n;
    drive(d, w, sz, sg, a, wd, mi, it);
    n = 0;
    while (!done[d] && n < 20) begin
      @(posedge CLK); #2;
      n++;
    end
    checks++;
    if (!done[d]) begin
      errors++;
      $display("FAIL done_timeout dut%0d: got no DONE expected DONE within 20 cycles", d);
    end
    @(posedge CLK); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    repeat (3) @(posedge CLK);
    #2;
    N_RST = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready_dut%0d", d), {31'd0, ready[d]}, 32'd1);
      chk($sformatf("rst_done_dut%0d", d), {31'd0, done[d]}, 32'd0);
      chk($sformatf("rst_err_dut%0d", d), {31'd0, err[d]}, 32'd0);
      chk($sformatf("rst_rdata_dut%0d", d), rdata[d], 32'd0);
      chk($sformatf("rst_maddr_dut%0d", d), maddr[d], 32'd0);
      chk($sformatf("rst_mout_dut%0d", d), mout[d], 32'd0);
      chk($sformatf("rst_nwe_dut%0d", d), {31'd0, nwe[d]}, 32'd1);
      chk($sformatf("rst_noe_dut%0d", d), {31'd0, noe[d]}, 32'd1);
    end

    // Default instance: loads, stores, rejects
    run(0, 0, 2'b00, 1, 32'h3, 32'h0, 32'h8081_8283,
        mk(2, 0, 32'hFFFF_FF80, 32'h0, 32'h0, 1, 0, 1, 0));
    run(0, 0, 2'b01, 0, 32'h2, 32'h0, 32'h8081_8283,
        mk(2, 0, 32'h0000_8081, 32'h0, 32'h0, 1, 0, 1, 0));
    run(0, 1, 2'b00, 0, 32'h5, 32'h0000_00AA, 32'h1122_3344,
        mk(4, 0, 32'h0000_8081, 32'h4, 32'h1122_AA44, 1, 1, 3, 2));
    run(0, 1, 2'b10, 0, 32'h2, 32'h1234_5678, 32'h1122_3344,
        mk(1, 1, 32'h0000_8081, 32'h0, 32'h0, 0, 0, 0, 0));
    run(0, 0, 2'b11, 0, 32'h0, 32'h0, 32'h1122_3344,
        mk(1, 1, 32'h0000_8081, 32'h0, 32'h0, 0, 0, 0, 0));
    run(0, 0, 2'b10, 0, 32'h8, 32'h0, 32'h1122_3344,
        mk(2, 0, 32'h1122_3344, 32'h8, 32'h0, 1, 0, 1, 0));
    run(0, 0, 2'b00, 0, 32'h1, 32'h0, 32'h1122_3344,
        mk(2, 0, 32'h0000_0033, 32'h0, 32'h0, 1, 0, 1, 0));
    run(0, 1, 2'b10, 0, 32'hC, 32'hDEAD_BEEF, 32'h1122_3344,
        mk(3, 0, 32'h0000_0033, 32'hC, 32'hDEAD_BEEF, 0, 1, 2, 2));
    run(0, 1, 2'b01, 0, 32'h2, 32'h1234_5678, 32'h1122_3344,
        mk(4, 0, 32'h0000_0033, 32'h0, 32'h5678_3344, 1, 1, 3, 2));
    run(0, 0, 2'b01, 0, 32'h1, 32'h0, 32'h1122_3344,
        mk(1, 1, 32'h0000_0033, 32'h0, 32'h0, 0, 0, 0, 0));
    run(0, 0, 2'b01, 1, 32'h0, 32'h0, 32'h0000_F00F,
        mk(2, 0, 32'hFFFF_F00F, 32'h0, 32'h0, 1, 0, 1, 0));

    // Stretched write pulse and hold
    run(1, 1, 2'b10, 0, 32'h10, 32'hCAFE_F00D, 32'h0,
        mk(6, 0, 32'h0, 32'h10, 32'hCAFE_F00D, 0, 3, 5, 5));

    // Reset in the middle of WR aborts without DONE
    drive(1, 1, 2'b10, 0, 32'h20, 32'h0000_0001, 32'h0,
          mk(6, 0, 32'h0, 32'h20, 32'h1, 0, 3, 5, 5));
    @(posedge CLK); #2;
    chk("rst_mid_pre_nwe", {31'd0, nwe[1]}, 32'd0);
    dn = done_n[1];
    N_RST = 1'b0;
    @(posedge CLK); #2;
    chk("rst_mid_nwe", {31'd0, nwe[1]}, 32'd1);
    chk("rst_mid_noe", {31'd0, noe[1]}, 32'd1);
    chk("rst_mid_done", {31'd0, done[1]}, 32'd0);
    @(posedge CLK); #2;
    N_RST = 1'b1;
    @(posedge CLK); #2;
    chk("rst_mid_ready", {31'd0, ready[1]}, 32'd1);
    repeat (6) @(posedge CLK);
    #2;
    chk("rst_mid_no_done", done_n[1] - dn, 32'd0);

    run(1, 1, 2'b10, 0, 32'h24, 32'h0BAD_CAFE, 32'h0,
        mk(6, 0, 32'h0, 32'h24, 32'h0BAD_CAFE, 0, 3, 5, 5));

    repeat (3) @(posedge CLK);
    #2;
    chk("strobe_overlap_cycles", overlap_n, 32'd0);
    chk("addr_misaligned_cycles", align_n, 32'd0);
    chk("pending_dut0", q0.size(), 32'd0);
    chk("pending_dut1", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
